lsu_ctrl: RTL and testbench

//  Load/store control stage between EX and the data RAM. Accepts memory requests from EX.

---
 rtl/lsu_ctrl_pkg.sv | 55 +++++
 rtl/lsu_ctrl_store_queue.sv | 65 ++++++
 rtl/lsu_ctrl.sv | 153 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store control stage: funct3 encodings, exception causes,
// store-queue entry layout and the small legality helpers used by the decode.
package lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } f3Ld;

    typedef enum logic [2:0] {
        ST_B = 3'b000,
        ST_H = 3'b001,
        ST_W = 3'b010
    } f3St;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        LD_MISAL = 2'b01,
        ST_MISAL = 2'b10,
        ILLEGAL  = 2'b11
    } lsuExc;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sq_entry_t;

    function automatic logic f3_ld_legal(input logic [2:0] f3);
        case (f3)
            LD_B, LD_H, LD_W, LD_BU, LD_HU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic f3_st_legal(input logic [2:0] f3);
        case (f3)
            ST_B, ST_H, ST_W: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_store_queue.sv
// In-order store queue: circular FIFO of {funct3, addr, wdata} with a head read port
// and a word-address match across all live entries.
module lsu_ctrl_store_queue
    import lsu_ctrl_pkg::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  sq_entry_t                   push_entry,
    input  logic                        pop,
    input  logic [29:0]                 match_word,
    output logic                        any_match,
    output sq_entry_t                   head_entry,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(SQ_DEPTH):0]   count
);

    localparam int AW = $clog2(SQ_DEPTH);

    sq_entry_t     mem_q [SQ_DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW:0]   count_q;

    assign full       = (count_q == (AW+1)'(SQ_DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_entry = mem_q[head_q];

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        any_match = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (({1'b0, AW'(i) - head_q} < count_q) && (mem_q[i].addr[31:2] == match_word))
                any_match = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                tail_q <= tail_q + 1'b1;
            if (pop)
                head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[tail_q] <= push_entry;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control between EX and the data RAM: legality decode, store queue,
// RAM port arbitration, and the registered WB result and exception pulse.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        ram_load,
    output logic        ram_store,
    output logic [2:0]  ram_funct3,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic        sq_empty
);

    logic                       is_ld;
    logic                       is_st;
    logic                       illegal;
    logic                       misal;
    logic                       fault;
    lsuExc                      cause;
    logic                       wb_free;
    logic                       ld_ok;
    logic                       st_ok;
    logic                       ld_go;
    logic                       sq_push;
    logic                       sq_pop;
    logic                       sq_full;
    logic                       sq_none;
    logic                       sq_match;
    logic [$clog2(SQ_DEPTH):0]  sq_count;
    sq_entry_t                  sq_in;
    sq_entry_t                  sq_head;

    logic        wb_vld_p1;
    logic [4:0]  wb_rd_p1;
    logic [31:0] wb_data_p1;
    logic        exc_vld_p1;
    lsuExc       exc_cause_p1;
    logic [31:0] exc_addr_p1;

    // ---- p0: request decode, arbitration and RAM issue ----
    always_comb begin
        is_ld   = req_load && !req_store;
        is_st   = req_store && !req_load;
        illegal = !(is_ld && f3_ld_legal(req_funct3)) && !(is_st && f3_st_legal(req_funct3));
        misal   = misaligned(req_funct3, req_addr[1:0]);
        fault   = illegal || misal;
        if (illegal)
            cause = ILLEGAL;
        else if (is_ld)
            cause = LD_MISAL;
        else
            cause = ST_MISAL;
    end

    // A full queue blocks loads, which leaves the port to the draining head.
    assign wb_free   = !wb_vld_p1 || wb_ready;
    assign ld_ok     = is_ld && !fault && wb_free && !sq_match && !sq_full;
    assign ld_go     = req_valid && ld_ok;
    assign sq_pop    = !sq_none && !ld_go;
    assign st_ok     = is_st && !fault && (!sq_full || sq_pop);
    assign sq_push   = req_valid && st_ok;
    assign req_ready = fault || ld_ok || st_ok;

    assign sq_in = '{funct3: req_funct3, addr: req_addr, wdata: req_wdata};

    lsu_ctrl_store_queue #(
        .SQ_DEPTH (SQ_DEPTH)
    ) u_sq (
        .clk        (clk),
        .rst        (rst),
        .push       (sq_push),
        .push_entry (sq_in),
        .pop        (sq_pop),
        .match_word (req_addr[31:2]),
        .any_match  (sq_match),
        .head_entry (sq_head),
        .full       (sq_full),
        .empty      (sq_none),
        .count      (sq_count)
    );

    always_comb begin
        ram_load   = 1'b0;
        ram_store  = 1'b0;
        ram_funct3 = 3'b000;
        ram_addr   = 32'h0;
        ram_wdata  = 32'h0;
        if (ld_go) begin
            ram_load   = 1'b1;
            ram_funct3 = req_funct3;
            ram_addr   = req_addr;
        end else if (sq_pop) begin
            ram_store  = 1'b1;
            ram_funct3 = sq_head.funct3;
            ram_addr   = sq_head.addr;
            ram_wdata  = sq_head.wdata;
        end
    end

    // ---- p1: WB result and exception registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_vld_p1    <= 1'b0;
            wb_rd_p1     <= '0;
            wb_data_p1   <= '0;
            exc_vld_p1   <= 1'b0;
            exc_cause_p1 <= NONE;
            exc_addr_p1  <= '0;
        end else begin
            if (ld_go) begin
                wb_vld_p1  <= 1'b1;
                wb_rd_p1   <= req_rd;
                wb_data_p1 <= ram_rdata;
            end else if (wb_ready) begin
                wb_vld_p1  <= 1'b0;
            end
            exc_vld_p1 <= req_valid && fault;
            if (req_valid && fault) begin
                exc_cause_p1 <= cause;
                exc_addr_p1  <= req_addr;
            end
        end
    end

    assign wb_valid  = wb_vld_p1;
    assign wb_rd     = wb_rd_p1;
    assign wb_data   = wb_data_p1;
    assign exc_valid = exc_vld_p1;
    assign exc_cause = exc_cause_p1;
    assign exc_addr  = exc_addr_p1;
    assign sq_empty  = (sq_count == '0);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array RAM environment, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_lsu_ctrl;

    localparam int SQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        ram_load, ram_store;
    logic [2:0]  ram_funct3;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        sq_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.SQ_DEPTH(SQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .ram_load(ram_load), .ram_store(ram_store), .ram_funct3(ram_funct3), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr), .sq_empty(sq_empty)
    );

    // RAM environment (mem) and the model's golden memory (gmem), both little-endian bytes.
    logic [7:0] mem  [4096];
    logic [7:0] gmem [4096];

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] env_word(input logic [31:0] a);
        logic [11:0] w;
        w = {a[11:2], 2'b00};
        return {mem[w + 12'd3], mem[w + 12'd2], mem[w + 12'd1], mem[w]};
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [11:0] w;
        w = {a[11:2], 2'b00};
        return {gmem[w + 12'd3], gmem[w + 12'd2], gmem[w + 12'd1], gmem[w]};
    endfunction

    assign ram_rdata = ram_load ? extend(env_word(ram_addr), ram_addr[1:0], ram_funct3) : 32'h0;

    always @(posedge clk) begin
        if (ram_store) begin
            mem[ram_addr[11:0]] <= ram_wdata[7:0];
            if (ram_funct3[1:0] != 2'b00)
                mem[ram_addr[11:0] + 12'd1] <= ram_wdata[15:8];
            if (ram_funct3[1:0] == 2'b10) begin
                mem[ram_addr[11:0] + 12'd2] <= ram_wdata[23:16];
                mem[ram_addr[11:0] + 12'd3] <= ram_wdata[31:24];
            end
        end
    end

    // Reference model state
    typedef struct packed { logic [2:0] f3; logic [31:0] addr; logic [31:0] data; } st_t;
    st_t         sq[$];
    logic        m_wbv, m_excv;
    logic [31:0] m_wbd, m_excaddr;
    logic [4:0]  m_wbrd;
    logic [1:0]  m_cause;
    logic        e_ready, e_ld, e_drain, e_push, e_fault;
    logic [1:0]  e_cause;
    logic [68:0] e_ram;

    task automatic model_reset();
        sq.delete();
        m_wbv = 0; m_wbd = 0; m_wbrd = 0;
        m_excv = 0; m_cause = 0; m_excaddr = 0;
    endtask

    task automatic model_eval();
        logic is_ld, is_st, match, full, wfree;
        int nb;
        is_ld = req_load && !req_store;
        is_st = req_store && !req_load;
        nb = 1 << req_funct3[1:0];
        e_fault = 1'b0;
        e_cause = 2'b00;
        if (!((is_ld && (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
              (is_st && (req_funct3 inside {3'b000, 3'b001, 3'b010})))) begin
            e_fault = 1'b1;
            e_cause = 2'b11;
        end else if ((req_addr % nb) != 0) begin
            e_fault = 1'b1;
            e_cause = is_ld ? 2'b01 : 2'b10;
        end
        match = 1'b0;
        foreach (sq[i]) if (sq[i].addr[31:2] == req_addr[31:2]) match = 1'b1;
        full    = (sq.size() == SQ_DEPTH);
        wfree   = !m_wbv || wb_ready;
        e_ld    = req_valid && is_ld && !e_fault && wfree && !match && !full;
        e_drain = (sq.size() > 0) && !e_ld;
        e_push  = req_valid && is_st && !e_fault && (!full || e_drain);
        e_ready = e_fault || e_ld || e_push;
        if (e_ld)
            e_ram = {1'b1, 1'b0, req_funct3, req_addr, 32'h0};
        else if (e_drain)
            e_ram = {1'b0, 1'b1, sq[0].f3, sq[0].addr, sq[0].data};
        else
            e_ram = '0;
    endtask

    task automatic model_commit();
        if (e_drain) begin
            gmem[sq[0].addr[11:0]] = sq[0].data[7:0];
            if (sq[0].f3[1:0] != 2'b00) gmem[sq[0].addr[11:0] + 12'd1] = sq[0].data[15:8];
            if (sq[0].f3[1:0] == 2'b10) begin
                gmem[sq[0].addr[11:0] + 12'd2] = sq[0].data[23:16];
                gmem[sq[0].addr[11:0] + 12'd3] = sq[0].data[31:24];
            end
            void'(sq.pop_front());
        end
        if (e_push) sq.push_back('{req_funct3, req_addr, req_wdata});
        if (e_ld) begin
            m_wbv  = 1'b1;
            m_wbd  = extend(gold_word(req_addr), req_addr[1:0], req_funct3);
            m_wbrd = req_rd;
        end else if (wb_ready) begin
            m_wbv = 1'b0;
        end
        m_excv = req_valid && e_fault;
        if (m_excv) begin
            m_cause   = e_cause;
            m_excaddr = req_addr;
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic wr);
        @(negedge clk);
        req_valid = v; req_load = ld; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = d; req_rd = rd; wb_ready = wr;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] saved;
        rst = 1'b0;
        req_valid = 0; req_load = 0; req_store = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; req_rd = 0; wb_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sq_empty, wb_valid, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL reset_wb: got empty=%b wbv=%b rd=%0d data=%h want 1 0 0 0", sq_empty, wb_valid, wb_rd, wb_data);
        end
        checks++;
        if ({exc_valid, exc_cause, exc_addr} !== 35'h0) begin
            errors++;
            $display("FAIL reset_exc: got v=%b cause=%b addr=%h want all zero", exc_valid, exc_cause, exc_addr);
        end
        checks++;
        if ({ram_load, ram_store, ram_funct3, ram_addr, ram_wdata} !== 69'h0) begin
            errors++;
            $display("FAIL reset_ram: got ld=%b st=%b addr=%h want idle", ram_load, ram_store, ram_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        saved = env_word(32'h100);
        drive(1, 0, 1, 3'b010, 32'h100, 32'h1234_5678, 5'd0, 1'b1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_sw_accept: got ready=%b want 1", req_ready);
        end
        tick();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1);
        checks++;
        if ({ram_store, ram_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL rst_drain_head: got st=%b addr=%h want 1 00000100", ram_store, ram_addr);
        end
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ram_store, sq_empty} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_drain: got st=%b empty=%b want 0 1", ram_store, sq_empty);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({env_word(32'h100), wb_valid} !== {saved, 1'b0}) begin
            errors++;
            $display("FAIL rst_ram_word: got %h wbv=%b want %h 0", env_word(32'h100), wb_valid, saved);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store_load_same();
        drive(1, 0, 1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd0, 1'b1);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw40_accept: got ready=%b want 1", req_ready);
        end
        tick();
        drive(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd5, 1'b1);
        checks++;
        if ({req_ready, ram_store, ram_addr, ram_wdata} !== {1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL lw40_stall: got ready=%b st=%b addr=%h wdata=%h want 0 1 00000040 deadbeef",
                     req_ready, ram_store, ram_addr, ram_wdata);
        end
        tick();
        drive(1, 1, 0, 3'b010, 32'h40, 32'h0, 5'd5, 1'b1);
        checks++;
        if ({req_ready, ram_load, ram_addr} !== {1'b1, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL lw40_issue: got ready=%b ld=%b addr=%h want 1 1 00000040", req_ready, ram_load, ram_addr);
        end
        tick();
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL lw40_wb: got v=%b rd=%0d data=%h want 1 5 deadbeef", wb_valid, wb_rd, wb_data);
        end
        idle(1);
    endtask

    task automatic test_byte_loads();
        drive(1, 0, 1, 3'b000, 32'h43, 32'h0000_0080, 5'd0, 1'b1);
        tick();
        idle(1);
        drive(1, 1, 0, 3'b000, 32'h43, 32'h0, 5'd7, 1'b1);
        tick();
        checks++;
        if (wb_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb43: got %h want ffffff80", wb_data);
        end
        drive(1, 1, 0, 3'b100, 32'h43, 32'h0, 5'd8, 1'b1);
        tick();
        checks++;
        if (wb_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu43: got %h want 00000080", wb_data);
        end
        drive(1, 1, 0, 3'b001, 32'h42, 32'h0, 5'd9, 1'b1);
        tick();
        checks++;
        if (wb_data !== m_wbd) begin
            errors++;
            $display("FAIL lh42: got %h want %h", wb_data, m_wbd);
        end
        idle(1);
    endtask

    task automatic test_misalign();
        drive(1, 1, 0, 3'b010, 32'h102, 32'h0, 5'd1, 1'b1);
        checks++;
        if ({req_ready, ram_load, ram_store} !== 3'b100) begin
            errors++;
            $display("FAIL lw102_port: got ready=%b ld=%b st=%b want 1 0 0", req_ready, ram_load, ram_store);
        end
        tick();
        checks++;
        if ({exc_valid, exc_cause, exc_addr} !== {1'b1, 2'b01, 32'h102}) begin
            errors++;
            $display("FAIL lw102_exc: got v=%b cause=%b addr=%h want 1 01 00000102", exc_valid, exc_cause, exc_addr);
        end
        idle(1);
        checks++;
        if (exc_valid !== 1'b0) begin
            errors++;
            $display("FAIL exc_pulse_len: got %b want 0", exc_valid);
        end
        drive(1, 0, 1, 3'b001, 32'h101, 32'h55, 5'd0, 1'b1);
        tick();
        checks++;
        if ({exc_valid, exc_cause, exc_addr, sq_empty} !== {1'b1, 2'b10, 32'h101, 1'b1}) begin
            errors++;
            $display("FAIL sh101_exc: got v=%b cause=%b addr=%h empty=%b want 1 10 00000101 1",
                     exc_valid, exc_cause, exc_addr, sq_empty);
        end
        drive(1, 1, 1, 3'b010, 32'h104, 32'h0, 5'd0, 1'b1);
        tick();
        checks++;
        if ({exc_valid, exc_cause} !== 3'b111) begin
            errors++;
            $display("FAIL ldst_both: got v=%b cause=%b want 1 11", exc_valid, exc_cause);
        end
        drive(1, 1, 0, 3'b011, 32'h108, 32'h0, 5'd0, 1'b1);
        tick();
        checks++;
        if ({exc_valid, exc_cause, exc_addr} !== {1'b1, 2'b11, 32'h108}) begin
            errors++;
            $display("FAIL ld_badf3: got v=%b cause=%b addr=%h want 1 11 00000108", exc_valid, exc_cause, exc_addr);
        end
        drive(1, 0, 1, 3'b100, 32'h10C, 32'h0, 5'd0, 1'b1);
        tick();
        checks++;
        if ({exc_valid, exc_cause} !== 3'b111) begin
            errors++;
            $display("FAIL st_badf3: got v=%b cause=%b want 1 11", exc_valid, exc_cause);
        end
        idle(1);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 3'b010, 32'h300 + 32'(4 * k), 32'hA000_0000 + 32'(k), 5'd0, 1'b1);
            checks++;
            if ({req_ready, ram_load, ram_store, ram_funct3, ram_addr, ram_wdata} !== {e_ready, e_ram}) begin
                errors++;
                $display("FAIL fill_sw%0d: got ready=%b st=%b addr=%h want ready=%b port=%h",
                         k, req_ready, ram_store, ram_addr, e_ready, e_ram);
            end
            tick();
            drive(1, 1, 0, 3'b010, 32'h380 + 32'(4 * k), 32'h0, 5'(k), 1'b1);
            checks++;
            if ({req_ready, ram_load, ram_store, ram_funct3, ram_addr, ram_wdata} !== {e_ready, e_ram}) begin
                errors++;
                $display("FAIL fill_lw%0d: got ready=%b ld=%b st=%b addr=%h want ready=%b port=%h",
                         k, req_ready, ram_load, ram_store, ram_addr, e_ready, e_ram);
            end
            tick();
        end
        idle(SQ_DEPTH + 2);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (env_word(32'h300 + 32'(4 * k)) !== 32'hA000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL fill_mem%0d: got %h want %h", k, env_word(32'h300 + 32'(4 * k)), 32'hA000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_wb_stall();
        logic [31:0] held;
        drive(1, 1, 0, 3'b010, 32'h200, 32'h0, 5'd3, 1'b1);
        tick();
        held = m_wbd;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 3'b010, 32'h204, 32'h0, 5'd4, 1'b0);
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL wb_stall_ready%0d: got %b want 0", k, req_ready);
            end
            tick();
            checks++;
            if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd3, held}) begin
                errors++;
                $display("FAIL wb_hold%0d: got v=%b rd=%0d data=%h want 1 3 %h", k, wb_valid, wb_rd, wb_data, held);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 3'b010, 32'h208 + 32'(4 * k), 32'h0, 5'(10 + k), 1'b1);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want 1", k, req_ready);
            end
            tick();
            checks++;
            if ({wb_valid, wb_rd, wb_data} !== {1'b1, m_wbrd, m_wbd}) begin
                errors++;
                $display("FAIL b2b_wb%0d: got v=%b rd=%0d data=%h want 1 %0d %h", k, wb_valid, wb_rd, wb_data, m_wbrd, m_wbd);
            end
        end
        idle(1);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wb_release: got %b want 0", wb_valid);
        end
    endtask

    task automatic test_random();
        logic        v, ld, st, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind, sel;
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 9) < 8);
            kind = $urandom_range(0, 19);
            ld   = (kind < 9) || (kind == 18);
            st   = (kind >= 9 && kind < 18) || (kind == 18);
            sel  = $urandom_range(0, 19);
            if (sel < 17)
                f3 = ld ? (sel % 5 == 3 ? 3'b100 : sel % 5 == 4 ? 3'b101 : 3'(sel % 5)) : 3'(sel % 3);
            else
                f3 = 3'($urandom_range(0, 7));
            a = 32'h200 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b00)     a = a + 32'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01)     a = a + 32'(2 * $urandom_range(0, 1));
            wr = ($urandom_range(0, 9) < 7);
            drive(v, ld, st, f3, a, $urandom, 5'($urandom), wr);
            if (v) begin
                checks++;
                if (req_ready !== e_ready) begin
                    errors++;
                    $display("FAIL rnd_ready@%0d: got %b want %b", n, req_ready, e_ready);
                end
            end
            checks++;
            if ({ram_load, ram_store, ram_funct3, ram_addr, ram_wdata} !== e_ram) begin
                errors++;
                $display("FAIL rnd_ram@%0d: got %h want %h", n,
                         {ram_load, ram_store, ram_funct3, ram_addr, ram_wdata}, e_ram);
            end
            tick();
            checks++;
            if ({wb_valid, wb_rd, wb_data} !== {m_wbv, m_wbrd, m_wbd}) begin
                errors++;
                $display("FAIL rnd_wb@%0d: got v=%b rd=%0d data=%h want v=%b rd=%0d data=%h",
                         n, wb_valid, wb_rd, wb_data, m_wbv, m_wbrd, m_wbd);
            end
            checks++;
            if ({exc_valid, exc_cause, exc_addr, sq_empty} !== {m_excv, m_cause, m_excaddr, sq.size() == 0}) begin
                errors++;
                $display("FAIL rnd_exc@%0d: got v=%b cause=%b addr=%h empty=%b want v=%b cause=%b addr=%h empty=%b",
                         n, exc_valid, exc_cause, exc_addr, sq_empty, m_excv, m_cause, m_excaddr, sq.size() == 0);
            end
        end
        idle(SQ_DEPTH + 2);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (env_word(32'h200 + 32'(4 * k)) !== gold_word(32'h200 + 32'(4 * k))) begin
                errors++;
                $display("FAIL rnd_mem%0d: got %h want %h", k, env_word(32'h200 + 32'(4 * k)),
                         gold_word(32'h200 + 32'(4 * k)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]  = 8'($urandom);
            gmem[i] = mem[i];
        end
        test_reset();
        test_store_load_same();
        test_byte_loads();
        test_misalign();
        test_fill();
        test_wb_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
